// File: rtl/lstm_pkg.sv
// lstm_pkg: shared definitions for the LSTM cell-state sequencer.
//   - default word length / fractional bits of the signed fixed-point format
//   - default clip magnitude for the optional c clamp (LSTM_CCLIP_EN)
//   - FSM state encoding for lstm_cstate_sched
package lstm_pkg;

  localparam int          LSTM_D_WL   = 16;
  localparam int          LSTM_D_FL   = 12;
  localparam logic [15:0] LSTM_C_CLIP = 16'h4000;  // 4.0 in Q4.12

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } cs_state_t;

endpackage

// File: rtl/lstm_cstate_sched_get_c.sv
// get_c: cell-state datapath, c_new = f*c_prev + i*g.
//   Q(D_WL-D_FL).D_FL signed; each product is truncated to the word format,
//   the sum wraps. Three register stages, in_valid -> o_valid latency 3.
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_in_valid         operands valid this cycle
//   i_f, i_i, i_g      gate values
//   i_ini_c            previous cell state
//   o_valid, o_d       result strobe / new cell state
module get_c #(
  parameter int D_WL = 16,
  parameter int D_FL = 12
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_in_valid,
  input  logic [D_WL-1:0] i_f,
  input  logic [D_WL-1:0] i_i,
  input  logic [D_WL-1:0] i_g,
  input  logic [D_WL-1:0] i_ini_c,
  output logic            o_valid,
  output logic [D_WL-1:0] o_d
);

  localparam int STAGES = 3;

  logic [STAGES:1]         r_vld_pipe;
  logic [D_WL-1:0]         r_fc, r_ig, r_sum, r_d;
  logic signed [2*D_WL-1:0] w_fc, w_ig;

  // Full-width signed products; sign-extend operands so the multiply is
  // evaluated at 2*D_WL bits.
  assign w_fc = $signed({{D_WL{i_f[D_WL-1]}}, i_f}) *
                $signed({{D_WL{i_ini_c[D_WL-1]}}, i_ini_c});
  assign w_ig = $signed({{D_WL{i_i[D_WL-1]}}, i_i}) *
                $signed({{D_WL{i_g[D_WL-1]}}, i_g});

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld_pipe <= '0;
      r_fc       <= '0;
      r_ig       <= '0;
      r_sum      <= '0;
      r_d        <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], i_in_valid};
      // Truncate back to the word format: drop D_FL fraction bits, keep D_WL.
      if (i_in_valid) begin
        r_fc <= D_WL'(w_fc >>> D_FL);
        r_ig <= D_WL'(w_ig >>> D_FL);
      end
      if (r_vld_pipe[1]) r_sum <= r_fc + r_ig;
      if (r_vld_pipe[2]) r_d   <= r_sum;
    end
  end

  assign o_valid = r_vld_pipe[STAGES];
  assign o_d     = r_d;

endmodule

// File: rtl/lstm_cstate_sched.sv
// lstm_cstate_sched: walks the N_HID hidden units of one timestep through a
// single get_c instance. Per unit: read f/i/g and previous c, compute, write
// the new c back to the c memory and forward it to the h stage.
// Optional feature: define LSTM_CCLIP_EN to clamp the written / forwarded
// cell state to [-C_CLIP, +C_CLIP] (combinational, no added latency).
// Ports:
//   i_clk, i_rst_n                  clock, synchronous active-low reset
//   i_start, i_first_step           timestep start; first_step => prev c = 0
//   i_gate_avail                    gate buffer holds entry at o_gate_addr
//   o_gate_rd, o_gate_addr          gate read (data on i_gate_* next cycle)
//   i_gate_f/i/g                    gate data
//   o_c_rd, o_c_rd_addr, i_c_rd_data  c-memory read port, 1-cycle latency
//   o_c_wr_en/addr/data             c-memory write port
//   o_c_out_valid/o_c_out/o_c_out_idx  new cell state to the h stage
//   o_busy, o_done, o_err           status; err is sticky until reset
module lstm_cstate_sched
  import lstm_pkg::*;
#(
  parameter int              D_WL   = LSTM_D_WL,
  parameter int              D_FL   = LSTM_D_FL,
  parameter int              N_HID  = 16,
  parameter int              AW     = $clog2(N_HID),
  parameter logic [D_WL-1:0] C_CLIP = D_WL'(LSTM_C_CLIP)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_first_step,
  input  logic            i_gate_avail,
  output logic            o_gate_rd,
  output logic [AW-1:0]   o_gate_addr,
  input  logic [D_WL-1:0] i_gate_f,
  input  logic [D_WL-1:0] i_gate_i,
  input  logic [D_WL-1:0] i_gate_g,
  output logic            o_c_rd,
  output logic [AW-1:0]   o_c_rd_addr,
  input  logic [D_WL-1:0] i_c_rd_data,
  output logic            o_c_wr_en,
  output logic [AW-1:0]   o_c_wr_addr,
  output logic [D_WL-1:0] o_c_wr_data,
  output logic            o_c_out_valid,
  output logic [D_WL-1:0] o_c_out,
  output logic [AW-1:0]   o_c_out_idx,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err
);

`ifdef LSTM_CCLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [AW-1:0]          LAST   = AW'(N_HID - 1);
  localparam logic signed [D_WL-1:0] W_HI   = $signed(C_CLIP);
  localparam logic signed [D_WL-1:0] W_LO   = -W_HI;

  cs_state_t       r_state;
  logic [AW-1:0]   r_iss_cnt, r_wr_cnt;
  logic            r_first_q, r_iss_vld, r_err;
  logic            w_issue, w_o_valid;
  logic [D_WL-1:0] w_ini_c, w_d, w_c_fin;

  // Issue whenever the gate entry for the current unit is present.
  assign w_issue = (r_state == ST_ISSUE) && i_gate_avail;
  // On the first timestep the c memory holds stale data; feed zero instead.
  assign w_ini_c = r_first_q ? '0 : i_c_rd_data;

  get_c #(.D_WL(D_WL), .D_FL(D_FL)) u_get_c (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_in_valid (r_iss_vld),
    .i_f        (i_gate_f),
    .i_i        (i_gate_i),
    .i_g        (i_gate_g),
    .i_ini_c    (w_ini_c),
    .o_valid    (w_o_valid),
    .o_d        (w_d)
  );

  always_comb begin
    w_c_fin = w_d;
    if (CLIP_EN) begin
      if ($signed(w_d) > W_HI)      w_c_fin = W_HI;
      else if ($signed(w_d) < W_LO) w_c_fin = W_LO;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_iss_cnt <= '0;
      r_wr_cnt  <= '0;
      r_first_q <= 1'b0;
      r_iss_vld <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_iss_vld <= w_issue;
      // Results return in issue order, so a plain counter tracks the address.
      if (w_o_valid) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_o_valid && (r_state == ST_IDLE || r_state == ST_DONE)) r_err <= 1'b1;
      case (r_state)
        ST_IDLE: if (i_start) begin
          r_state   <= ST_ISSUE;
          r_first_q <= i_first_step;
          r_iss_cnt <= '0;
          r_wr_cnt  <= '0;
        end
        ST_ISSUE: if (i_gate_avail) begin
          r_iss_cnt <= r_iss_cnt + 1'b1;
          if (r_iss_cnt == LAST) r_state <= ST_DRAIN;
        end
        ST_DRAIN: if (w_o_valid && r_wr_cnt == LAST) r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_gate_rd     = w_issue;
  assign o_gate_addr   = r_iss_cnt;
  assign o_c_rd        = w_issue && !r_first_q;
  assign o_c_rd_addr   = r_iss_cnt;
  // Write address always lags the read address, so the dual-port c memory
  // never sees a same-address read/write in one cycle.
  assign o_c_wr_en     = w_o_valid;
  assign o_c_wr_addr   = r_wr_cnt;
  assign o_c_wr_data   = w_c_fin;
  assign o_c_out_valid = w_o_valid;
  assign o_c_out       = w_c_fin;
  assign o_c_out_idx   = r_wr_cnt;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = (r_state == ST_DONE);
  assign o_err         = r_err;

endmodule

// File: tb/tb_lstm_cstate_sched.sv
module tb_lstm_cstate_sched;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n, start, first_step, gate_avail;
  logic        gate_rd, c_rd, c_wr_en, c_out_valid, busy, done, err;
  logic [3:0]  gate_addr, c_rd_addr, c_wr_addr, c_out_idx;
  logic [15:0] gate_f, gate_i, gate_g, c_rd_data, c_wr_data, c_out;

  always #5 clk = ~clk;

  lstm_cstate_sched dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_first_step(first_step),
    .i_gate_avail(gate_avail), .o_gate_rd(gate_rd), .o_gate_addr(gate_addr),
    .i_gate_f(gate_f), .i_gate_i(gate_i), .i_gate_g(gate_g),
    .o_c_rd(c_rd), .o_c_rd_addr(c_rd_addr), .i_c_rd_data(c_rd_data),
    .o_c_wr_en(c_wr_en), .o_c_wr_addr(c_wr_addr), .o_c_wr_data(c_wr_data),
    .o_c_out_valid(c_out_valid), .o_c_out(c_out), .o_c_out_idx(c_out_idx),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  // Gate buffer and c memory models (1-cycle read latency).
  logic [15:0] gf [N];
  logic [15:0] gi [N];
  logic [15:0] gg [N];
  logic [15:0] c_mem [N];
  always @(posedge clk) begin
    if (gate_rd) begin
      gate_f <= gf[gate_addr];
      gate_i <= gi[gate_addr];
      gate_g <= gg[gate_addr];
    end
    if (c_rd) c_rd_data <= c_mem[c_rd_addr];
    if (c_wr_en) c_mem[c_wr_addr] <= c_wr_data;
  end

  typedef struct { int addr; logic [15:0] data; int cyc; } exp_t;
  exp_t sb[$];

  logic [15:0] mc [N];   // model of c memory contents
  int total = 0, bad = 0;
  int done_cyc, n_done, exp_done;
  bit done_seen, saw_crd, cur_first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mdl(input logic [15:0] f, c, i, g);
    int a, b;
    logic [15:0] s;
    a = int'($signed(f)) * int'($signed(c));
    b = int'($signed(i)) * int'($signed(g));
    s = 16'(a >>> 12) + 16'(b >>> 12);
`ifdef LSTM_CCLIP_EN
    if ($signed(s) > $signed(16'h4000)) s = 16'h4000;
    else if ($signed(s) < $signed(16'hC000)) s = 16'hC000;
`endif
    return s;
  endfunction

  // Monitor: cycle 0 is the cycle in which start is seen while idle.
  initial begin
    int ncyc, base, rc;
    exp_t e;
    ncyc = 0; base = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (start && !busy && rst_n) base = ncyc;
      rc = ncyc - base;
      if (c_wr_en) begin
        chk("wr_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("wr_addr", c_wr_addr, e.addr);
          chk("wr_data", c_wr_data, e.data);
          chk("wr_cycle", rc, e.cyc);
          chk("out_valid", c_out_valid, 1);
          chk("out_data", c_out, e.data);
          chk("out_idx", c_out_idx, e.addr);
        end
      end
      if (c_rd && cur_first) saw_crd = 1'b1;
      if (done) begin done_seen = 1'b1; done_cyc = rc; n_done++; end
    end
  end

  // Load gate vectors and push expectations for the first nw units.
  task automatic prep(input bit first, input logic [15:0] f, i, g, gstep,
                      input bit toggle, input int nw);
    logic [15:0] d;
    for (int j = 0; j < N; j++) begin
      gf[j] = f; gi[j] = i; gg[j] = g + 16'(j) * gstep;
      d = mdl(f, first ? 16'h0 : mc[j], i, gg[j]);
      if (j < nw) begin
        sb.push_back('{addr: j, data: d, cyc: toggle ? 2*j + 5 : j + 5});
        mc[j] = d;
      end
    end
    exp_done = toggle ? 2*(N-1) + 6 : N + 5;
  endtask

  task automatic run(input bit first, input bit toggle, input int rst_at, input int xs);
    bit fin;
    fin = 1'b0; cur_first = first; done_seen = 1'b0; done_cyc = -1;
    n_done = 0; saw_crd = 1'b0;
    for (int k = 0; k < 80 && !fin; k++) begin
      if (rst_at >= 0 && k == rst_at + 1) begin
        chk("rst_gate_rd", gate_rd, 0);
        chk("rst_c_rd", c_rd, 0);
        chk("rst_wr_en", c_wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_vec", {c_wr_data, c_out, c_wr_addr, c_out_idx, gate_addr, c_rd_addr}, 0);
      end
      if (rst_at >= 0 && k == rst_at + 6) fin = 1'b1;
      if (rst_at < 0 && done_seen && k == done_cyc + 1) begin
        chk("idle_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        fin = 1'b1;
      end
      if (!fin) begin
        start      = (k == 0) || (k == xs);
        first_step = (k == 0) ? first : !first;
        gate_avail = toggle ? k[0] : 1'b1;
        rst_n      = (k != rst_at);
        @(posedge clk); #1;
      end
    end
    start = 1'b0; gate_avail = 1'b0; rst_n = 1'b1;
    if (rst_at < 0) begin
      chk("done_cycle", done_cyc, exp_done);
      chk("done_count", n_done, 1);
    end else chk("done_count", n_done, 0);
    chk("sb_empty", sb.size(), 0);
    chk("err", err, 0);
    if (first) chk("no_c_rd", saw_crd, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; first_step = 1'b0; gate_avail = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_gate_rd", gate_rd, 0);
    chk("reset_wr_en", c_wr_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done_err", {done, err, c_out_valid, c_rd}, 0);
    chk("reset_vec", {c_wr_data, c_out, c_wr_addr, c_out_idx, gate_addr, c_rd_addr}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; gate_avail = 1'b0;
    @(posedge clk); #1;

    // First timestep: previous c ignored (f nonzero to expose misuse).
    prep(1, 16'h7FFF, 16'h1000, 16'h0C00, 16'h0, 0, N);  run(1, 0, -1, -1);
    // Set c = 2.0 everywhere.
    prep(1, 16'h0000, 16'h1000, 16'h2000, 16'h0, 0, N);  run(1, 0, -1, -1);
    // No-stall: 0.5*2.0 + 1.0*0.5 = 1.5 -> 0x1800, writes in cycles 5..20.
    prep(0, 16'h0800, 16'h1000, 16'h0800, 16'h0, 0, N);  run(0, 0, -1, -1);
    // Alternating gate_avail, per-unit g values to catch address slips.
    prep(0, 16'h1000, 16'h1000, 16'h0100, 16'h0100, 1, N); run(0, 1, -1, -1);
    // Reset during cycle 8: units 0..3 written, nothing after.
    prep(0, 16'h0800, 16'h1000, 16'h0800, 16'h0, 0, 4);  run(0, 0, 8, -1);
    // Normal run afterwards, with a stray start in cycle 3.
    prep(0, 16'h0800, 16'h1000, 16'h0800, 16'h0, 0, N);  run(0, 0, -1, 3);
    // Clip: c = 3.5, then 1.0*3.5 + 1.0*1.0 = 4.5.
    prep(1, 16'h0000, 16'h1000, 16'h3800, 16'h0, 0, N);  run(1, 0, -1, -1);
    prep(0, 16'h1000, 16'h1000, 16'h1000, 16'h0, 0, N);  run(0, 0, -1, -1);
`ifdef LSTM_CCLIP_EN
    chk("clip_pos", mc[0], 16'h4000);
`else
    chk("clip_pos", mc[0], 16'h4800);
`endif
    // Negated: c = -3.5, g = -1.0 -> -4.5.
    prep(1, 16'h0000, 16'h1000, 16'hC800, 16'h0, 0, N);  run(1, 0, -1, -1);
    prep(0, 16'h1000, 16'h1000, 16'hF000, 16'h0, 0, N);  run(0, 0, -1, -1);
`ifdef LSTM_CCLIP_EN
    chk("clip_neg", mc[5], 16'hC000);
`else
    chk("clip_neg", mc[5], 16'hB800);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
